text_buffer: RTL

//  Character-cell store and write engine directly upstream of the VGA renderer.
//  - Renderer presents a cell address (cx, cy) and receives ascii, colour and highlight for that cell.
//  - Terminal logic issues commands (put char, newline, clear, set cursor) over a valid/ready handshake.
//  - An internal cursor and FSM perform the cell writes, full-screen clear and, optionally, scroll.

---
 rtl/text_buffer_if.sv | 21 ++
 rtl/text_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_if.sv
// text_buffer_if: command handshake between terminal logic (master) and text_buffer (slave).
interface text_buffer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_ascii;
    logic [5:0] cmd_colour;
    logic       cmd_hl;
    logic [6:0] cmd_x;
    logic [5:0] cmd_y;

    modport master (
        output cmd_valid, cmd_op, cmd_ascii, cmd_colour, cmd_hl, cmd_x, cmd_y,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ascii, cmd_colour, cmd_hl, cmd_x, cmd_y,
        output cmd_ready
    );
endinterface

// File: rtl/text_buffer.sv
// text_buffer: character-cell store and command-driven write engine feeding the VGA renderer.
// Cells are {hl, colour, ascii} addressed {cy, cx}; cy = R-1 is the top line on screen.
// Optional feature: define TEXT_BUFFER_SCROLL_EN to scroll the screen up on a newline at the
// bottom line instead of wrapping the cursor to the top.
module text_buffer #(
    parameter int unsigned COLS_S = 80,
    parameter int unsigned ROWS_S = 60,
    parameter int unsigned COLS_L = 40,
    parameter int unsigned ROWS_L = 30,
    parameter logic [6:0]  BLANK  = 7'h20
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         sL,
    text_buffer_if.slave cmd,
    input  logic [6:0]   cx,
    input  logic [5:0]   cy,
    output logic [6:0]   cascii,
    output logic [5:0]   ccolour,
    output logic         chl,
    output logic [6:0]   cur_x,
    output logic [5:0]   cur_y,
    output logic         busy
);

    localparam logic [1:0] OpPut     = 2'b00;
    localparam logic [1:0] OpNewline = 2'b01;
    localparam logic [1:0] OpClear   = 2'b10;
    localparam logic [1:0] OpSetcur  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StClear
`ifdef TEXT_BUFFER_SCROLL_EN
        ,
        StScrlRd,
        StScrlWr,
        StScrlFill
`endif
    } state_e;

    logic [13:0] mem [8192];

    state_e      state_q;
    logic        sl_q, sl_prev_q;
    logic        mode_chg;
    logic [6:0]  c_max;
    logic [5:0]  r_max;
    logic [6:0]  cur_x_q;
    logic [5:0]  cur_y_q;
    logic [6:0]  ex_q;
    logic [5:0]  ey_q;
    logic [5:0]  clr_colour_q;
    logic        clr_hl_q;
    logic [13:0] rd_q;
    logic        accept;
    logic        newline;
    logic        nl_bottom;
    logic [5:0]  nl_y;
    logic        we;
    logic [12:0] waddr;
    logic [13:0] wdata;
`ifdef TEXT_BUFFER_SCROLL_EN
    logic [13:0] scr_q;
`endif

    assign mode_chg      = sl_q ^ sl_prev_q;
    assign c_max         = sl_q ? 7'(COLS_L - 1) : 7'(COLS_S - 1);
    assign r_max         = sl_q ? 6'(ROWS_L - 1) : 6'(ROWS_S - 1);
    assign cmd.cmd_ready = (state_q == StIdle) & ~mode_chg;
    assign accept        = cmd.cmd_valid & cmd.cmd_ready;
    assign newline       = accept & ((cmd.cmd_op == OpNewline) |
                                     ((cmd.cmd_op == OpPut) & (cur_x_q == c_max)));
    assign busy          = (state_q != StIdle);
    assign cur_x         = cur_x_q;
    assign cur_y         = cur_y_q;
    assign {chl, ccolour, cascii} = rd_q;

    // Register font mode twice so a change is seen as a one-cycle mode_chg pulse.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sl_q      <= sL;
            sl_prev_q <= sL;
        end else begin
            sl_q      <= sL;
            sl_prev_q <= sl_q;
        end
    end

    // Cursor row after a newline: step down, or handle the bottom line.
    always_comb begin
        nl_bottom = (cur_y_q == 6'd0);
        nl_y      = cur_y_q - 6'd1;
        if (nl_bottom) begin
`ifdef TEXT_BUFFER_SCROLL_EN
            nl_y = 6'd0;
`else
            nl_y = r_max;
`endif
        end
    end

    // Single write port shared by PUT, CLEAR and the scroll engine.
    always_comb begin
        we    = 1'b0;
        waddr = {cur_y_q, cur_x_q};
        wdata = {cmd.cmd_hl, cmd.cmd_colour, cmd.cmd_ascii};
        unique case (state_q)
            StIdle: we = accept && (cmd.cmd_op == OpPut);
            StClear: begin
                we    = 1'b1;
                waddr = {ey_q, ex_q};
                wdata = {clr_hl_q, clr_colour_q, BLANK};
            end
`ifdef TEXT_BUFFER_SCROLL_EN
            StScrlRd: we = 1'b0;
            StScrlWr: begin
                we    = 1'b1;
                waddr = {ey_q + 6'd1, ex_q};
                wdata = scr_q;
            end
            StScrlFill: begin
                we    = 1'b1;
                waddr = {6'd0, ex_q};
                wdata = {1'b0, 6'd0, BLANK};
            end
`endif
            default: we = 1'b0;
        endcase
        // A mode change or reset aborts the engine before it touches another cell.
        we = we & resetn & ~mode_chg;
    end

    // Cell store write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Render read port: one cycle latency, returns pre-write data on a collision.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_q <= 14'd0;
        end else begin
            rd_q <= mem[{cy, cx}];
        end
    end

`ifdef TEXT_BUFFER_SCROLL_EN
    // Engine read port: fetch the source cell of a scroll copy.
    always_ff @(posedge clk) begin
        if (state_q == StScrlRd) begin
            scr_q <= mem[{ey_q, ex_q}];
        end
    end
`endif

    // Command FSM, cursor and engine counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= StIdle;
            cur_x_q      <= 7'd0;
            cur_y_q      <= sL ? 6'(ROWS_L - 1) : 6'(ROWS_S - 1);
            ex_q         <= 7'd0;
            ey_q         <= 6'd0;
            clr_colour_q <= 6'd0;
            clr_hl_q     <= 1'b0;
        end else if (mode_chg) begin
            state_q <= StIdle;
            cur_x_q <= 7'd0;
            cur_y_q <= r_max;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        unique case (cmd.cmd_op)
                            OpPut:     cur_x_q <= (cur_x_q == c_max) ? 7'd0 : cur_x_q + 7'd1;
                            OpNewline: cur_x_q <= 7'd0;
                            OpClear: begin
                                state_q      <= StClear;
                                ex_q         <= 7'd0;
                                ey_q         <= 6'd0;
                                clr_colour_q <= cmd.cmd_colour;
                                clr_hl_q     <= cmd.cmd_hl;
                            end
                            OpSetcur: begin
                                cur_x_q <= (cmd.cmd_x > c_max) ? c_max : cmd.cmd_x;
                                cur_y_q <= (cmd.cmd_y > r_max) ? r_max : cmd.cmd_y;
                            end
                        endcase
                    end
                    if (newline) begin
                        cur_y_q <= nl_y;
`ifdef TEXT_BUFFER_SCROLL_EN
                        if (nl_bottom) begin
                            state_q <= StScrlRd;
                            ex_q    <= 7'd0;
                            ey_q    <= r_max - 6'd1;
                        end
`endif
                    end
                end
                StClear: begin
                    if (ex_q == c_max) begin
                        ex_q <= 7'd0;
                        if (ey_q == r_max) begin
                            state_q <= StIdle;
                            cur_x_q <= 7'd0;
                            cur_y_q <= r_max;
                        end else begin
                            ey_q <= ey_q + 6'd1;
                        end
                    end else begin
                        ex_q <= ex_q + 7'd1;
                    end
                end
`ifdef TEXT_BUFFER_SCROLL_EN
                StScrlRd: state_q <= StScrlWr;
                StScrlWr: begin
                    state_q <= StScrlRd;
                    if (ex_q == c_max) begin
                        ex_q <= 7'd0;
                        if (ey_q == 6'd0) begin
                            state_q <= StScrlFill;
                        end else begin
                            ey_q <= ey_q - 6'd1;
                        end
                    end else begin
                        ex_q <= ex_q + 7'd1;
                    end
                end
                StScrlFill: begin
                    if (ex_q == c_max) begin
                        state_q <= StIdle;
                    end else begin
                        ex_q <= ex_q + 7'd1;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
